// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the fetch/data arbiter: request/response
// structs, the arbiter state encoding and the fixed fetch transfer size.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_I = 3'd1,
        ST_ADDR_D = 3'd2,
        ST_DATA_I = 3'd3,
        ST_DATA_D = 3'd4
    } arb_state_t;

    // Instruction fetches are always full 32-bit words.
    localparam logic [2:0] FETCH_SIZE = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one memory request port between the fetch
// bus (ibus) and the data bus (dbus). One transaction outstanding at a time.
// dbus normally wins; after STARVE_MAX consecutive dbus grants with an ibus
// request waiting, ibus is granted once.
//
// Handshake: a request is offered on m_valid with stable fields until the
// memory answers m_addr_ok in the same cycle; the response is taken on the
// cycle m_data_ok is high (possibly the same cycle as m_addr_ok). The
// memory's addr_ok/data_ok are forwarded combinationally only to the
// granted requester; the other side sees all-zero responses.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        m_valid,
    output logic        m_is_write,
    output logic [31:0] m_addr,
    output logic [2:0]  m_size,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output arb_state_t  dbg_state
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] starve_cnt, starve_d;

    assign dbg_state = state_q;

    // State and starvation counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state_q    <= state_d;
            starve_cnt <= starve_d;
        end
    end

    // Grant decision, memory request muxing and response forwarding.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_cnt;
        m_valid    = 1'b0;
        m_is_write = 1'b0;
        m_addr     = '0;
        m_size     = '0;
        m_strobe   = '0;
        m_wdata    = '0;
        iresp      = '0;
        dresp      = '0;

        case (state_q)
            ST_IDLE: begin
                if (dreq.valid && ((starve_cnt < STARVE_LIM) || !ireq.valid)) begin
                    state_d = ST_ADDR_D;
                    if (ireq.valid)
                        starve_d = (starve_cnt < STARVE_LIM) ? starve_cnt + CNT_ONE : STARVE_LIM;
                    else
                        starve_d = '0;
                end else if (ireq.valid) begin
                    state_d  = ST_ADDR_I;
                    starve_d = '0;
                end
            end

            ST_ADDR_I: begin
                m_valid       = 1'b1;
                m_addr        = ireq.addr;
                m_size        = FETCH_SIZE;
                iresp.addr_ok = m_addr_ok;
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        iresp.data_ok = 1'b1;
                        iresp.data    = m_rdata;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_DATA_I;
                    end
                end
            end

            ST_ADDR_D: begin
                m_valid       = 1'b1;
                m_is_write    = |dreq.strobe;
                m_addr        = dreq.addr;
                m_size        = dreq.size;
                m_strobe      = dreq.strobe;
                m_wdata       = dreq.data;
                dresp.addr_ok = m_addr_ok;
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        dresp.data_ok = 1'b1;
                        dresp.data    = m_rdata;
                        state_d       = ST_IDLE;
                    end else begin
                        state_d = ST_DATA_D;
                    end
                end
            end

            ST_DATA_I: begin
                if (m_data_ok) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = m_rdata;
                    state_d       = ST_IDLE;
                end
            end

            ST_DATA_D: begin
                if (m_data_ok) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = m_rdata;
                    state_d       = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, fetch timing, store forwarding,
// combined addr/data acceptance, starvation grant order, mid-transaction reset.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clk;
    logic        resetn;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        m_valid;
    logic        m_is_write;
    logic [31:0] m_addr;
    logic [2:0]  m_size;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    arb_state_t  dbg_state;

    int errors;
    int checks;

    bus_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ireq       (ireq),
        .iresp      (iresp),
        .dreq       (dreq),
        .dresp      (dresp),
        .m_valid    (m_valid),
        .m_is_write (m_is_write),
        .m_addr     (m_addr),
        .m_size     (m_size),
        .m_strobe   (m_strobe),
        .m_wdata    (m_wdata),
        .m_addr_ok  (m_addr_ok),
        .m_data_ok  (m_data_ok),
        .m_rdata    (m_rdata),
        .dbg_state  (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq      = '0;
        dreq      = '0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = '0;
    endtask

    task automatic test_reset();
        logic [109:0] all_out;
        resetn = 1'b0;
        ireq = '{valid: 1'b1, addr: 32'h1111_0000};
        dreq = '{valid: 1'b1, addr: 32'h2222_0000, size: 3'd2, strobe: 4'hF, data: 32'hCAFE_F00D};
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'h5555_AAAA;
        step();
        step();
        all_out = {m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata, iresp[33:32], dresp[33:32], iresp.data};
        checks++;
        if (all_out !== '0 || dresp !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h required 0", all_out, dresp);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        clear_inputs();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        // cycle 0: request appears, arbiter still idle
        ireq = '{valid: 1'b1, addr: 32'hBFC0_0000};
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c0: state %0d m_valid %b required IDLE/0", dbg_state, m_valid);
        end
        // cycle 1: address phase, memory not ready
        step();
        checks++;
        if (dbg_state !== ST_ADDR_I || m_valid !== 1'b1 || m_addr !== 32'hBFC0_0000 ||
            m_size !== 3'd2 || m_strobe !== 4'h0 || m_is_write !== 1'b0 || iresp.addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c1: state %0d v %b addr %h size %0d strb %h wr %b aok %b",
                     dbg_state, m_valid, m_addr, m_size, m_strobe, m_is_write, iresp.addr_ok);
        end
        // cycle 2: memory accepts
        step();
        m_addr_ok = 1'b1;
        #1;
        checks++;
        if (iresp.addr_ok !== 1'b1 || dresp.addr_ok !== 1'b0 || iresp.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c2: iaok %b daok %b idok %b required 1/0/0",
                     iresp.addr_ok, dresp.addr_ok, iresp.data_ok);
        end
        // cycle 3: waiting for data
        step();
        m_addr_ok = 1'b0;
        ireq      = '0;
        #1;
        checks++;
        if (dbg_state !== ST_DATA_I || m_valid !== 1'b0 || iresp.data_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_c3: state %0d v %b dok %b required DATA_I/0/0",
                     dbg_state, m_valid, iresp.data_ok);
        end
        // cycle 4: data returns
        step();
        m_data_ok = 1'b1;
        m_rdata   = 32'h2408_0001;
        #1;
        checks++;
        if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h2408_0001 || dresp !== '0) begin
            errors++;
            $display("FAIL fetch_c4: dok %b data %h dresp %h required 1/24080001/0",
                     iresp.data_ok, iresp.data, dresp);
        end
        // cycle 5: idle again
        step();
        clear_inputs();
        #1;
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL fetch_c5: state %0d required IDLE", dbg_state);
        end
    endtask

    task automatic test_store();
        dreq = '{valid: 1'b1, addr: 32'h0000_1000, size: 3'd1, strobe: 4'b0011, data: 32'hDEAD_BEEF};
        step();
        checks++;
        if (dbg_state !== ST_ADDR_D || m_valid !== 1'b1 || m_is_write !== 1'b1 ||
            m_strobe !== 4'b0011 || m_wdata !== 32'hDEAD_BEEF || m_size !== 3'd1 ||
            m_addr !== 32'h0000_1000 || iresp !== '0) begin
            errors++;
            $display("FAIL store_addr: state %0d wr %b strb %h wdata %h size %0d addr %h iresp %h",
                     dbg_state, m_is_write, m_strobe, m_wdata, m_size, m_addr, iresp);
        end
        m_addr_ok = 1'b1;
        #1;
        checks++;
        if (dresp.addr_ok !== 1'b1 || iresp !== '0) begin
            errors++;
            $display("FAIL store_aok: daok %b iresp %h required 1/0", dresp.addr_ok, iresp);
        end
        step();
        m_addr_ok = 1'b0;
        dreq      = '0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h1234_5678;
        #1;
        checks++;
        if (dbg_state !== ST_DATA_D || dresp.data_ok !== 1'b1 || dresp.data !== 32'h1234_5678 || iresp !== '0) begin
            errors++;
            $display("FAIL store_data: state %0d dok %b data %h iresp %h required DATA_D/1/12345678/0",
                     dbg_state, dresp.data_ok, dresp.data, iresp);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL store_idle: state %0d required IDLE", dbg_state);
        end
    endtask

    task automatic test_same_cycle();
        dreq = '{valid: 1'b1, addr: 32'h0000_2004, size: 3'd2, strobe: 4'h0, data: 32'h0};
        step();
        m_addr_ok = 1'b1;
        m_data_ok = 1'b1;
        m_rdata   = 32'hA5A5_0F0F;
        #1;
        checks++;
        if (dbg_state !== ST_ADDR_D || m_is_write !== 1'b0 || dresp.addr_ok !== 1'b1 ||
            dresp.data_ok !== 1'b1 || dresp.data !== 32'hA5A5_0F0F || iresp !== '0) begin
            errors++;
            $display("FAIL same_cycle_resp: state %0d wr %b aok %b dok %b data %h",
                     dbg_state, m_is_write, dresp.addr_ok, dresp.data_ok, dresp.data);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || dresp !== '0) begin
            errors++;
            $display("FAIL same_cycle_idle: state %0d dresp %h required IDLE/0", dbg_state, dresp);
        end
    endtask

    task automatic test_starvation();
        arb_state_t exp_grant [10];
        exp_grant = '{ST_ADDR_D, ST_ADDR_D, ST_ADDR_D, ST_ADDR_D, ST_ADDR_I,
                      ST_ADDR_D, ST_ADDR_D, ST_ADDR_D, ST_ADDR_D, ST_ADDR_I};
        ireq = '{valid: 1'b1, addr: 32'hBFC0_0100};
        dreq = '{valid: 1'b1, addr: 32'h0000_3000, size: 3'd2, strobe: 4'h0, data: 32'h0};
        for (int g = 0; g < 10; g++) begin
            step();
            checks++;
            if (dbg_state !== exp_grant[g]) begin
                errors++;
                $display("FAIL starve_grant%0d: state %0d required %0d", g, dbg_state, exp_grant[g]);
            end
            m_addr_ok = 1'b1;
            step();
            m_addr_ok = 1'b0;
            m_data_ok = 1'b1;
            step();
            m_data_ok = 1'b0;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        dreq = '{valid: 1'b1, addr: 32'h0000_4000, size: 3'd2, strobe: 4'hF, data: 32'h0BAD_F00D};
        step();
        m_addr_ok = 1'b1;
        step();
        m_addr_ok = 1'b0;
        dreq      = '0;
        #1;
        checks++;
        if (dbg_state !== ST_DATA_D) begin
            errors++;
            $display("FAIL rstmid_pre: state %0d required DATA_D", dbg_state);
        end
        // assert reset between clock edges while memory is answering
        m_data_ok = 1'b1;
        m_rdata   = 32'h7777_7777;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || dresp !== '0 || iresp !== '0 || m_valid !== 1'b0 ||
            m_is_write !== 1'b0 || m_addr !== '0 || m_wdata !== '0 || m_strobe !== '0 || m_size !== '0) begin
            errors++;
            $display("FAIL rstmid_async: state %0d dresp %h iresp %h m_valid %b",
                     dbg_state, dresp, iresp, m_valid);
        end
        m_data_ok = 1'b0;
        step();
        resetn = 1'b1;
        // stray memory handshakes after release must be ignored
        step();
        m_data_ok = 1'b1;
        m_addr_ok = 1'b1;
        #1;
        checks++;
        if (iresp !== '0 || dresp !== '0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stray: iresp %h dresp %h m_valid %b required 0", iresp, dresp, m_valid);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmid_stray_state: state %0d required IDLE", dbg_state);
        end
        // a fresh fetch is served normally
        ireq = '{valid: 1'b1, addr: 32'hBFC0_0004};
        step();
        m_addr_ok = 1'b1;
        #1;
        checks++;
        if (dbg_state !== ST_ADDR_I || m_addr !== 32'hBFC0_0004 || iresp.addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fetch_addr: state %0d addr %h aok %b", dbg_state, m_addr, iresp.addr_ok);
        end
        step();
        m_addr_ok = 1'b0;
        ireq      = '0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h3C1D_8000;
        #1;
        checks++;
        if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h3C1D_8000) begin
            errors++;
            $display("FAIL rstmid_fetch_data: dok %b data %h required 1/3c1d8000", iresp.data_ok, iresp.data);
        end
        step();
        clear_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_fetch();
        test_store();
        test_same_cycle();
        test_starvation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive dbus grants allowed while an ibus request waits.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 ireq  in  ibus_req_t  fetch request: valid, addr[31:0].
REQ-005 iresp  out  ibus_resp_t  fetch response: addr_ok, data_ok, data[31:0].
REQ-006 dreq  in  dbus_req_t  data request: valid, addr[31:0], size[2:0], strobe[3:0], data[31:0].
REQ-007 dresp  out  dbus_resp_t  data response: addr_ok, data_ok, data[31:0].
REQ-008 m_valid, m_is_write, m_addr[31:0], m_size[2:0], m_strobe[3:0], m_wdata[31:0]  out  shared memory request port.
REQ-009 m_addr_ok, m_data_ok  in  1 each; m_rdata  in  32  shared memory response port.

Function
REQ-010 FSM states: IDLE, ADDR_I, ADDR_D, DATA_I, DATA_D; at most one transaction outstanding.
REQ-011 IDLE: dreq.valid and (starve_cnt < STARVE_MAX or !ireq.valid) -> ADDR_D; else ireq.valid -> ADDR_I; else stay IDLE; decision costs one cycle, m_valid=0 in IDLE.
REQ-012 ADDR_I: m_valid=1, m_addr=ireq.addr, m_size=3'd2, m_strobe=0, m_is_write=0; ADDR_D: fields forwarded combinationally from dreq, m_is_write=|dreq.strobe.
REQ-013 ADDR_x: m_addr_ok forwarded same cycle to granted requester's addr_ok; on m_addr_ok move to DATA_x, else hold (requester keeps valid/fields stable).
REQ-014 DATA_x: m_valid=0; m_data_ok forwarded same cycle to granted requester's data_ok with data=m_rdata; on m_data_ok return to IDLE.
REQ-015 m_addr_ok and m_data_ok both high in ADDR_x: both forwarded same cycle, next state IDLE.
REQ-016 Non-granted requester sees addr_ok=0, data_ok=0, data=0 every cycle.
REQ-017 m_data_ok outside DATA_x/ADDR_x, or m_addr_ok while m_valid=0: ignored, no state change.
REQ-018 starve_cnt (width clog2(STARVE_MAX+1)): on IDLE->ADDR_D with ireq.valid, increment, saturating at STARVE_MAX; on IDLE->ADDR_I, or IDLE->ADDR_D with !ireq.valid, clear to 0.
REQ-019 Requester dropping valid in ADDR_x before addr_ok: undefined for upstream; arbiter still holds grant until m_addr_ok.
REQ-020 Fetch transaction returns exactly m_rdata; dbus write responses also forward m_rdata unmodified.

Reset
REQ-021 resetn low: state=IDLE, starve_cnt=0 immediately, independent of clk.
REQ-022 During reset all outputs 0: m_valid, m_is_write, m_addr, m_size, m_strobe, m_wdata, iresp, dresp.
REQ-023 Reset mid-transaction abandons it; late m_data_ok after reset release falls under REQ-017.

Structure
REQ-024 ibus_req_t, ibus_resp_t, dbus_req_t, dbus_resp_t from the shared refcpu definitions header; FSM state enum arb_state_t and the fixed fetch size constant defined in that shared package.
REQ-025 Single module; no sub-module; starve counter and FSM inline.

Verification
REQ-026 Fetch only: ireq.valid, addr=0xBFC00000; m_addr_ok cycle 2, m_data_ok cycle 4 with rdata=0x24080001 -> ADDR_I in cycle 1, iresp.addr_ok cycle 2, iresp.data_ok+data=0x24080001 cycle 4, IDLE cycle 5.
REQ-027 Simultaneous ireq+dreq with STARVE_MAX=4, held continuously, 1-cycle memory -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-028 Store: dreq strobe=4'b0011, size=1, data=0xDEAD_BEEF -> m_is_write=1, m_strobe=4'b0011, m_wdata=0xDEADBEEF; iresp stays 0 throughout.
REQ-029 m_addr_ok and m_data_ok asserted same cycle in ADDR_D -> dresp.addr_ok and dresp.data_ok high that cycle; IDLE next cycle.
REQ-030 resetn low while in DATA_D -> outputs 0 asynchronously; after release a stray m_data_ok produces no iresp/dresp pulse; next ireq served normally.
